rr_grant_scheduler: RTL and testbench

//  Round-robin scheduler that shares one resource between 8 requesters.
//  It selects one requester, holds its grant until the requester releases
//  or a hold timeout expires, then rotates priority. It drives a 3-bit

---
 rtl/rr_grant_scheduler.sv | 138 +++++++++++++
 tb/tb_rr_grant_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_scheduler.sv
// -----------------------------------------------------------------------------
// rr_grant_scheduler
//
// Purpose:
//   Shares one resource between 8 requesters using round-robin priority.
//   A grant is held until the grantee signals done, withdraws its request,
//   or (optionally) a hold timeout expires. After every grant ends, priority
//   rotates to the requester just after the previous grantee.
//
// Ports:
//   clk          in   1  single clock, rising edge
//   rst          in   1  synchronous, active-high reset
//   req          in   8  request vector, bit i = requester i wants the resource
//   done         in   1  current grantee releases the resource this cycle
//   gnt          out  8  one-hot decode of gnt_idx while a grant is active, else 0
//   gnt_idx      out  3  index of the current (or most recent) grantee
//   gnt_valid    out  1  a grant is active
//   timeout_err  out  1  one-cycle pulse after a grant is force-revoked
//   state_dbg    out  1  FSM state (0 = IDLE, 1 = BUSY) for observation
//
// Handshake:
//   req is a level. Sampled in IDLE, a nonzero req produces a grant that is
//   visible from the next cycle. While BUSY, the grant ends at the next edge
//   when done=1 or req[gnt_idx]=0 in the current cycle, or when the hold
//   timeout is reached. An IDLE cycle always separates two grants.
//
// Parameters:
//   TIMEOUT  max cycles one grant may be held; 0 disables the timeout.
//            Legal nonzero values are 2..255.
// -----------------------------------------------------------------------------
module rr_grant_scheduler #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout_err,
    output logic       state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Timeout compare value: the grant is revoked at the edge that ends the
    // cycle in which hold_cnt reaches TIMEOUT-1, giving TIMEOUT held cycles.
    localparam logic       TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = 8'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic       terr_q, terr_d;

    logic [2:0] pick_idx;
    logic [2:0] cand;
    logic       release_w;
    logic       timeout_w;

    // Rotating priority pick: first set bit at or after ptr, wrapping.
    // Scanning offsets from highest to lowest lets the smallest offset win.
    always_comb begin
        pick_idx = ptr_q;
        cand     = '0;
        for (int i = 7; i >= 0; i--) begin
            cand = ptr_q + 3'(i);
            if (req[cand]) begin
                pick_idx = cand;
            end
        end
    end

    // Release has priority over timeout when both happen in the same cycle.
    assign release_w = done | ~req[idx_q];
    assign timeout_w = TO_EN && (hold_q == TO_LAST) && !release_w;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = pick_idx;
                    hold_d  = 8'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (release_w) begin
                    ptr_d   = idx_q + 3'd1;
                    state_d = IDLE;
                end else if (timeout_w) begin
                    ptr_d   = idx_q + 3'd1;
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
            hold_q  <= 8'd0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            terr_q  <= terr_d;
        end
    end

    // gnt_idx keeps its last value while idle; gnt is gated by the grant.
    assign gnt_valid   = (state_q == BUSY);
    assign gnt_idx     = idx_q;
    assign gnt         = gnt_valid ? (8'b1 << idx_q) : 8'h00;
    assign timeout_err = terr_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rr_grant_scheduler
//
// Directed bench for rr_grant_scheduler (TIMEOUT = 16). A behavioural model of
// the arbitration rules is stepped on every rising edge and compared against
// the DUT on every falling edge; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_rr_grant_scheduler;

    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] req  = 8'h00;
    logic       done = 1'b0;

    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout_err;
    logic       state_dbg;

    always #5 clk = ~clk;

    rr_grant_scheduler #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_valid   (gnt_valid),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_held counts cycles the current grant has been visible (1 on first).
    bit m_busy = 1'b0;
    int m_idx  = 0;
    int m_ptr  = 0;
    int m_held = 0;
    bit m_terr = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_idx  = 0;
            m_ptr  = 0;
            m_held = 0;
            m_terr = 1'b0;
        end else if (!m_busy) begin
            m_terr = 1'b0;
            if (req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (req[(m_ptr + k) % 8]) begin
                        m_idx = (m_ptr + k) % 8;
                        break;
                    end
                end
                m_busy = 1'b1;
                m_held = 1;
            end
        end else begin
            m_terr = 1'b0;
            if (done || !req[m_idx]) begin
                m_busy = 1'b0;
                m_ptr  = (m_idx + 1) % 8;
            end else if (TO != 0 && m_held >= TO) begin
                m_busy = 1'b0;
                m_terr = 1'b1;
                m_ptr  = (m_idx + 1) % 8;
            end else begin
                m_held++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt", gnt, m_busy ? (8'h01 << m_idx) : 8'h00);
            chk("gnt_idx", 8'(gnt_idx), 8'(m_idx));
            chk("gnt_valid", 8'(gnt_valid), 8'(m_busy));
            chk("timeout_err", 8'(timeout_err), 8'(m_terr));
            chk("state_dbg", 8'(state_dbg), 8'(m_busy));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_grant(input int exp, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gnt_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL wait_grant: no grant within %0d cycles, expected idx %0d", budget, exp);
        end else begin
            chk("grant_order", 8'(gnt_idx), 8'(exp));
        end
    endtask

    task automatic release_now();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int cnt;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("reset_gnt", gnt, 8'h00);
        chk("reset_valid", 8'(gnt_valid), 8'h00);
        chk("reset_terr", 8'(timeout_err), 8'h00);

        // Single request from idx 5.
        req = 8'h20;
        wait_grant(5, 4);
        chk("t1_gnt", gnt, 8'h20);

        // Release 5 -> ptr 6; req 0x41 grants 6 then wraps to 0.
        release_now();
        chk("t3_idle_after_release", 8'(gnt_valid), 8'h00);
        req = 8'h41;
        wait_grant(6, 4);
        chk("t3_gnt6", gnt, 8'h40);
        release_now();
        wait_grant(0, 4);
        chk("t3_gnt0", gnt, 8'h01);
        req = 8'h00;
        release_now();

        // Full rotation with all requesting, starting from reset priority.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            wait_grant(k % 8, 4);
            if (k == 0) chk("t2_first_gnt", gnt, 8'h01);
            release_now();
        end
        req = 8'h00;
        @(negedge clk);

        // Timeout on idx 3 held without done (ptr is 1 here).
        req = 8'h08;
        wait_grant(3, 4);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt_valid) cnt++;
            else break;
        end
        chk("t4_hold_cycles", 8'(cnt), 8'd16);
        chk("t4_terr_pulse", 8'(timeout_err), 8'h01);
        req = 8'h09;
        wait_grant(0, 4);
        chk("t4_gnt0_after_timeout", gnt, 8'h01);
        chk("t4_terr_cleared", 8'(timeout_err), 8'h00);
        req = 8'h00;
        release_now();

        // Reset in the middle of a grant to idx 2.
        req = 8'h04;
        wait_grant(2, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_gnt_after_rst", gnt, 8'h00);
        chk("t5_valid_after_rst", 8'(gnt_valid), 8'h00);
        req = 8'h05;
        wait_grant(0, 4);
        chk("t5_gnt0", gnt, 8'h01);
        req = 8'h00;
        release_now();

        // Withdraw request of idx 1, then done while idle does nothing.
        req = 8'h02;
        wait_grant(1, 4);
        req = 8'h00;
        @(negedge clk);
        chk("t6_withdraw", 8'(gnt_valid), 8'h00);
        done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_done_idle", gnt, 8'h00);
        end
        done = 1'b0;

        // done arrives in the last allowed cycle: normal release, no error.
        req = 8'h08;
        wait_grant(3, 4);
        repeat (15) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("t7_released", 8'(gnt_valid), 8'h00);
        chk("t7_no_terr", 8'(timeout_err), 8'h00);
        req = 8'h00;

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
